// File: rtl/buffer_seq.sv
// Fill/drain sequencer for the dual-port word buffer: loads N words from an upstream
// stream through port B, then replays them R times downstream through port A.
module buffer_seq #(
    parameter int WWORD = 32,
    parameter int DEPTH = 24,
    parameter int WREP  = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [11:0]      num_words,
    input  logic [WREP-1:0]  rep_cnt,
    input  logic             clear,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WWORD-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WWORD-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic             done,
    output logic             cena,
    output logic [11:0]      aa,
    input  logic [WWORD-1:0] qa,
    output logic             cenb,
    output logic [11:0]      ab,
    output logic [WWORD-1:0] db
);

    localparam int WC = 12 + WREP;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN} state_t;

    state_t           r_state;
    logic [11:0]      r_n;
    logic [11:0]      r_wr_ptr;
    logic [11:0]      r_rd_ptr;
    logic [WC-1:0]    r_total;
    logic [WC-1:0]    r_issued;
    logic [WC-1:0]    r_out_cnt;
    logic             r_inflight;
    logic [WWORD-1:0] r_fifo [2];
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_fifo_cnt;
    logic             r_done;

    logic [11:0]      w_n_eff;
    logic [WREP-1:0]  w_r_eff;
    logic [WC-1:0]    w_total;
    logic             w_wr;
    logic             w_pop;
    logic             w_issue;
    logic             w_last_pop;

    always_comb begin
        w_n_eff    = (num_words > 12'(DEPTH)) ? 12'(DEPTH) : num_words;
        w_r_eff    = (rep_cnt == '0) ? WREP'(1) : rep_cnt;
        w_total    = WC'(w_n_eff) * WC'(w_r_eff);

        // Writes and reads are suppressed in a clear cycle so an abort never touches the buffer.
        s_ready    = (r_state == S_FILL) && !clear;
        w_wr       = s_ready && s_valid;

        m_valid    = (r_fifo_cnt != 2'd0);
        m_data     = r_fifo[r_head];
        m_last     = m_valid && (r_out_cnt == r_total - WC'(1));
        w_pop      = m_valid && m_ready;
        w_last_pop = w_pop && m_last;

        // Issue only when the FIFO is guaranteed to have room for the word one cycle later.
        w_issue    = (r_state == S_DRAIN) && !clear && (r_issued < r_total) &&
                     (({1'b0, r_fifo_cnt} + {2'b0, r_inflight}) <= (3'd1 + {2'b0, w_pop}));

        cena       = !w_issue;
        aa         = w_issue ? r_rd_ptr : '0;
        cenb       = !w_wr;
        ab         = w_wr ? r_wr_ptr : '0;
        db         = w_wr ? s_data : '0;

        busy       = (r_state != S_IDLE);
        done       = r_done;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_n        <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_total    <= '0;
            r_issued   <= '0;
            r_out_cnt  <= '0;
            r_inflight <= 1'b0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_fifo_cnt <= '0;
            r_done     <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            if (clear) begin
                r_state    <= S_IDLE;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_issued   <= '0;
                r_out_cnt  <= '0;
                r_inflight <= 1'b0;
                r_head     <= 1'b0;
                r_tail     <= 1'b0;
                r_fifo_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_n       <= w_n_eff;
                            r_total   <= w_total;
                            r_wr_ptr  <= '0;
                            r_rd_ptr  <= '0;
                            r_issued  <= '0;
                            r_out_cnt <= '0;
                            if (w_n_eff == 12'd0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state <= S_FILL;
                            end
                        end
                    end

                    S_FILL: begin
                        if (w_wr) begin
                            r_wr_ptr <= r_wr_ptr + 12'd1;
                            if (r_wr_ptr == r_n - 12'd1) begin
                                r_state <= S_DRAIN;
                            end
                        end
                    end

                    S_DRAIN: begin
                        if (w_issue) begin
                            r_issued <= r_issued + WC'(1);
                            r_rd_ptr <= (r_rd_ptr == r_n - 12'd1) ? 12'd0 : r_rd_ptr + 12'd1;
                        end
                        r_inflight <= w_issue;
                        if (r_inflight) begin
                            r_fifo[r_tail] <= qa;
                            r_tail         <= ~r_tail;
                        end
                        if (w_pop) begin
                            r_head    <= ~r_head;
                            r_out_cnt <= r_out_cnt + WC'(1);
                        end
                        r_fifo_cnt <= r_fifo_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
                        if (w_last_pop) begin
                            r_state    <= S_IDLE;
                            r_done     <= 1'b1;
                            r_wr_ptr   <= '0;
                            r_rd_ptr   <= '0;
                            r_issued   <= '0;
                            r_out_cnt  <= '0;
                            r_inflight <= 1'b0;
                            r_head     <= 1'b0;
                            r_tail     <= 1'b0;
                            r_fifo_cnt <= '0;
                        end
                    end

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_buffer_seq.sv
// Directed bench for buffer_seq with a behavioural 1-cycle-latency buffer model.
module tb_buffer_seq;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [11:0] num_words;
    logic [7:0]  rep_cnt;
    logic        clear;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;
    logic        cena;
    logic [11:0] aa;
    logic [31:0] qa = '0;
    logic        cenb;
    logic [11:0] ab;
    logic [31:0] db;

    logic [31:0] mem [4096];

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          c;
        logic [11:0] a;
        logic [31:0] d;
        logic        l;
    } ent_t;

    ent_t wr_q[$];
    ent_t rd_q[$];
    ent_t out_q[$];
    int   done_q[$];

    int          cyc_n = 0;
    int          occ = 0;
    int          occ_bad = 0;
    int          cenb_bad = 0;
    int          stab_bad = 0;
    int          both_bad = 0;
    logic        hold_prev = 1'b0;
    logic [31:0] prev_data = '0;
    int          rdy_pat [6] = '{1, 0, 0, 1, 0, 1};

    buffer_seq #(.WWORD(32), .DEPTH(24), .WREP(8)) dut (
        .clk(clk), .rstn(rstn), .start(start), .num_words(num_words), .rep_cnt(rep_cnt),
        .clear(clear), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done), .cena(cena), .aa(aa), .qa(qa),
        .cenb(cenb), .ab(ab), .db(db)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cenb === 1'b0) mem[ab] <= db;
        if (cena === 1'b0) qa <= mem[aa];
    end

    // Samples one cycle just after the inputs were driven, then moves to the next negedge.
    task automatic tick;
        int pop;
        #1;
        pop = (m_valid && m_ready) ? 1 : 0;
        if (cenb === 1'b0) begin
            wr_q.push_back('{cyc_n, ab, db, 1'b0});
            if (!(s_valid && s_ready)) cenb_bad++;
        end else if (s_valid && s_ready) begin
            cenb_bad++;
        end
        if (cena === 1'b0 && cenb === 1'b0) both_bad++;
        if (cena === 1'b0) begin
            rd_q.push_back('{cyc_n, aa, 32'h0, 1'b0});
            if (occ - pop > 1) occ_bad++;
        end
        if (hold_prev && (m_valid !== 1'b1 || m_data !== prev_data)) stab_bad++;
        hold_prev = m_valid && !m_ready;
        prev_data = m_data;
        if (pop == 1) out_q.push_back('{cyc_n, 12'h0, m_data, m_last});
        if (done === 1'b1) done_q.push_back(cyc_n);
        occ = occ + ((cena === 1'b0) ? 1 : 0) - pop;
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic log_clear;
        wr_q.delete(); rd_q.delete(); out_q.delete(); done_q.delete();
        occ = 0; occ_bad = 0; cenb_bad = 0; stab_bad = 0; both_bad = 0; hold_prev = 1'b0;
    endtask

    task automatic kick(input int n, input int r);
        num_words = 12'(n); rep_cnt = 8'(r); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1; s_data = 32'(base + i);
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic run_drain(input int budget, input int mode);
        for (int k = 0; k < budget && done_q.size() == 0; k++) begin
            m_ready = (mode == 0) ? 1'b1 : (rdy_pat[cyc_n % 6] != 0);
            tick();
        end
        m_ready = 1'b1;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (cena !== 1'b1 || cenb !== 1'b1) begin errors++; $display("FAIL reset_cen: cena=%b cenb=%b want 1 1", cena, cenb); end
        checks++; if (aa !== 12'h0 || ab !== 12'h0 || db !== 32'h0) begin errors++; $display("FAIL reset_addr: aa=%h ab=%h db=%h want 0", aa, ab, db); end
        checks++; if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0) begin errors++; $display("FAIL reset_hs: s_ready=%b m_valid=%b m_last=%b want 0", s_ready, m_valid, m_last); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_status: busy=%b done=%b want 0", busy, done); end
    endtask

    task automatic test_basic;
        log_clear();
        m_ready = 1'b1;
        kick(4, 1);
        fill(4, 'hA0);
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL basic_sready_drop: got %b want 0", s_ready); end
        run_drain(40, 0);
        checks++; if (wr_q.size() != 4) begin errors++; $display("FAIL basic_wr_count: got %0d want 4", wr_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (wr_q[i].a !== 12'(i) || wr_q[i].d !== 32'('hA0 + i) || wr_q[i].c != wr_q[0].c + i)
                begin errors++; $display("FAIL basic_wr%0d: ab=%h db=%h cyc=%0d want ab=%h db=%h cyc=%0d", i, wr_q[i].a, wr_q[i].d, wr_q[i].c, i, 'hA0 + i, wr_q[0].c + i); end
        end
        checks++; if (rd_q.size() != 4) begin errors++; $display("FAIL basic_rd_count: got %0d want 4", rd_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (rd_q[i].a !== 12'(i) || rd_q[i].c != wr_q[3].c + 1 + i)
                begin errors++; $display("FAIL basic_rd%0d: aa=%h cyc=%0d want aa=%h cyc=%0d", i, rd_q[i].a, rd_q[i].c, i, wr_q[3].c + 1 + i); end
        end
        checks++; if (out_q.size() != 4) begin errors++; $display("FAIL basic_out_count: got %0d want 4", out_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (out_q[i].d !== 32'('hA0 + i) || out_q[i].l !== (i == 3) || out_q[i].c != wr_q[3].c + 3 + i)
                begin errors++; $display("FAIL basic_out%0d: data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d", i, out_q[i].d, out_q[i].l, out_q[i].c, 'hA0 + i, (i == 3), wr_q[3].c + 3 + i); end
        end
        checks++; if (done_q.size() != 1 || out_q.size() != 4 || done_q[0] != out_q[3].c + 1)
            begin errors++; $display("FAIL basic_done: pulses=%0d want 1 one cycle after last word", done_q.size()); end
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", busy); end
        checks++; if (both_bad != 0) begin errors++; $display("FAIL basic_port_overlap: got %0d want 0", both_bad); end
    endtask

    task automatic test_repeat;
        log_clear();
        kick(3, 2);
        fill(3, 'hB0);
        run_drain(40, 0);
        checks++; if (out_q.size() != 6 || rd_q.size() != 6) begin errors++; $display("FAIL rep_count: out=%0d rd=%0d want 6 6", out_q.size(), rd_q.size()); end
        else for (int i = 0; i < 6; i++) begin
            checks++; if (out_q[i].d !== 32'('hB0 + i % 3) || out_q[i].l !== (i == 5) || rd_q[i].a !== 12'(i % 3))
                begin errors++; $display("FAIL rep_word%0d: data=%h last=%b aa=%h want data=%h last=%b aa=%h", i, out_q[i].d, out_q[i].l, rd_q[i].a, 'hB0 + i % 3, (i == 5), i % 3); end
        end
        checks++; if (done_q.size() != 1) begin errors++; $display("FAIL rep_done: got %0d want 1", done_q.size()); end
    endtask

    task automatic test_backpressure;
        log_clear();
        kick(5, 1);
        fill(5, 'hC0);
        run_drain(80, 1);
        checks++; if (out_q.size() != 5) begin errors++; $display("FAIL bp_count: got %0d want 5", out_q.size()); end
        else for (int i = 0; i < 5; i++) begin
            checks++; if (out_q[i].d !== 32'('hC0 + i) || out_q[i].l !== (i == 4))
                begin errors++; $display("FAIL bp_word%0d: data=%h last=%b want data=%h last=%b", i, out_q[i].d, out_q[i].l, 'hC0 + i, (i == 4)); end
        end
        checks++; if (stab_bad != 0) begin errors++; $display("FAIL bp_stable: got %0d violations want 0", stab_bad); end
        checks++; if (occ_bad != 0) begin errors++; $display("FAIL bp_fifo_full_read: got %0d violations want 0", occ_bad); end
        checks++; if (done_q.size() != 1) begin errors++; $display("FAIL bp_done: got %0d want 1", done_q.size()); end
    endtask

    task automatic test_clamp;
        int maxab;
        log_clear();
        m_ready = 1'b1;
        kick(30, 1);
        for (int k = 0; k < 32; k++) begin
            s_valid = 1'b1; s_data = 32'('hD00 + wr_q.size());
            tick();
        end
        s_valid = 1'b0;
        run_drain(60, 0);
        maxab = 0;
        foreach (wr_q[i]) if (int'(wr_q[i].a) > maxab) maxab = int'(wr_q[i].a);
        checks++; if (wr_q.size() != 24 || maxab != 23) begin errors++; $display("FAIL clamp_writes: count=%0d max_ab=%0d want 24 23", wr_q.size(), maxab); end
        checks++; if (cenb_bad != 0) begin errors++; $display("FAIL clamp_cenb: got %0d violations want 0", cenb_bad); end
        checks++; if (out_q.size() != 24) begin errors++; $display("FAIL clamp_out_count: got %0d want 24", out_q.size()); end
        else for (int i = 0; i < 24; i++) begin
            checks++; if (out_q[i].d !== 32'('hD00 + i) || out_q[i].l !== (i == 23))
                begin errors++; $display("FAIL clamp_word%0d: data=%h last=%b want data=%h last=%b", i, out_q[i].d, out_q[i].l, 'hD00 + i, (i == 23)); end
        end
    endtask

    task automatic test_zero;
        int c0;
        log_clear();
        c0 = cyc_n;
        s_valid = 1'b1; s_data = 32'h55;
        kick(0, 1);
        #1;
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_done: done=%b busy=%b want 1 0", done, busy); end
        for (int k = 0; k < 5; k++) tick();
        s_valid = 1'b0;
        checks++; if (wr_q.size() != 0 || rd_q.size() != 0) begin errors++; $display("FAIL zero_ports: writes=%0d reads=%0d want 0 0", wr_q.size(), rd_q.size()); end
        checks++; if (done_q.size() != 1 || done_q[0] != c0 + 1) begin errors++; $display("FAIL zero_pulse: pulses=%0d want 1 at start+1", done_q.size()); end
    endtask

    task automatic test_rep0;
        log_clear();
        kick(2, 0);
        fill(2, 'h50);
        run_drain(40, 0);
        checks++; if (out_q.size() != 2) begin errors++; $display("FAIL rep0_count: got %0d want 2", out_q.size()); end
        else begin
            checks++; if (out_q[0].d !== 32'h50 || out_q[1].d !== 32'h51 || out_q[0].l !== 1'b0 || out_q[1].l !== 1'b1)
                begin errors++; $display("FAIL rep0_words: %h/%b %h/%b want 50/0 51/1", out_q[0].d, out_q[0].l, out_q[1].d, out_q[1].l); end
        end
        checks++; if (done_q.size() != 1) begin errors++; $display("FAIL rep0_done: got %0d want 1", done_q.size()); end
    endtask

    task automatic test_stall;
        int sv_pat [7] = '{1, 0, 1, 1, 0, 0, 1};
        int hs_off [4] = '{0, 2, 3, 6};
        int c0;
        log_clear();
        kick(4, 1);
        c0 = cyc_n;
        for (int k = 0; k < 7; k++) begin
            s_valid = (sv_pat[k] != 0); s_data = 32'('hE0 + wr_q.size());
            tick();
        end
        s_valid = 1'b0;
        run_drain(40, 0);
        checks++; if (cenb_bad != 0) begin errors++; $display("FAIL stall_cenb: got %0d violations want 0", cenb_bad); end
        checks++; if (wr_q.size() != 4) begin errors++; $display("FAIL stall_count: got %0d want 4", wr_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (wr_q[i].a !== 12'(i) || wr_q[i].d !== 32'('hE0 + i) || wr_q[i].c != c0 + hs_off[i])
                begin errors++; $display("FAIL stall_wr%0d: ab=%h db=%h cyc=%0d want ab=%h db=%h cyc=%0d", i, wr_q[i].a, wr_q[i].d, wr_q[i].c, i, 'hE0 + i, c0 + hs_off[i]); end
        end
        checks++; if (out_q.size() != 4 || out_q[3].d !== 32'hE3) begin errors++; $display("FAIL stall_out: count=%0d want 4 ending E3", out_q.size()); end
    endtask

    task automatic test_clear;
        log_clear();
        m_ready = 1'b1;
        kick(4, 1);
        fill(4, 'hF0);
        for (int k = 0; k < 20 && out_q.size() < 2; k++) tick();
        m_ready = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0; m_ready = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL clear_idle: busy=%b m_valid=%b want 0 0", busy, m_valid); end
        for (int k = 0; k < 5; k++) tick();
        checks++; if (out_q.size() != 2 || done_q.size() != 0) begin errors++; $display("FAIL clear_quiet: outputs=%0d dones=%0d want 2 0", out_q.size(), done_q.size()); end
        log_clear();
        kick(2, 1);
        fill(2, 'h60);
        run_drain(40, 0);
        checks++; if (out_q.size() != 2 || out_q[0].d !== 32'h60 || out_q[1].d !== 32'h61 || out_q[1].l !== 1'b1)
            begin errors++; $display("FAIL clear_next_job: count=%0d want 60,61 with last", out_q.size()); end
        checks++; if (done_q.size() != 1) begin errors++; $display("FAIL clear_next_done: got %0d want 1", done_q.size()); end
    endtask

    task automatic test_async_reset;
        log_clear();
        kick(4, 1);
        s_valid = 1'b1; s_data = 32'h70; tick();
        s_data = 32'h71; tick();
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (cena !== 1'b1 || cenb !== 1'b1) begin errors++; $display("FAIL areset_cen: cena=%b cenb=%b want 1 1", cena, cenb); end
        checks++; if (aa !== 12'h0 || ab !== 12'h0 || db !== 32'h0) begin errors++; $display("FAIL areset_addr: aa=%h ab=%h db=%h want 0", aa, ab, db); end
        checks++; if (s_ready !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0 || done !== 1'b0 || m_last !== 1'b0)
            begin errors++; $display("FAIL areset_status: s_ready=%b busy=%b m_valid=%b done=%b m_last=%b want 0", s_ready, busy, m_valid, done, m_last); end
        s_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; num_words = '0; rep_cnt = '0; clear = 1'b0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        test_basic();
        test_repeat();
        test_backpressure();
        test_clamp();
        test_zero();
        test_rep0();
        test_stall();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
